// File: rtl/branch_unit_bht.sv
// branch_unit_bht
//   Owns the architectural PC and resolves RV32I JAL/JALR/Bxx into the next
//   PC and a link address. A direct-mapped table of 2-bit saturating
//   counters predicts taken/not-taken for the current PC and flags
//   mispredicts on resolved conditional branches. Taken targets that break
//   the configured alignment raise a one-cycle trap and leave the PC alone.
//
// Parameters
//   XLEN       PC/operand width (>= 16)
//   RESET_PC   pc_out value after reset (truncated/extended to XLEN)
//   BHT_DEPTH  counter entries, power of 2, 2..256
//   ALIGN      required target alignment in bytes: 4, or 2 (compressed ISA)
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   enable         one-cycle strobe: execute instr this cycle
//   instr          instruction word (opcode [6:0], funct3 [14:12])
//   op1, op2, op3  rs1 value, rs2 value, sign-extended immediate
//   pc_out         current PC
//   ret_addr       link address (pc+4) of the last executed instruction
//   predict_taken  BHT prediction for pc_out (combinational table read)
//   mispredict     pulse: resolved branch disagreed with the prediction
//   trap           pulse: taken target misaligned
//   trap_addr      offending target, held until the next trap
//   done           pulse, the cycle after every accepted enable
module branch_unit_bht #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned ALIGN     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] op3,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ret_addr,
  output logic            predict_taken,
  output logic            mispredict,
  output logic            trap,
  output logic [XLEN-1:0] trap_addr,
  output logic            done
);

  localparam int unsigned IDXW = $clog2(BHT_DEPTH);

  typedef enum logic [6:0] {
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ret_q;
  logic [XLEN-1:0] trap_addr_q;
  logic            mispredict_q;
  logic            trap_q;
  logic            done_q;
  // Cleared by reset, set by the first clock edge afterwards; keeps an
  // enable that coincides with the reset-release edge from being executed.
  logic            armed_q;
  logic [1:0]      bht [BHT_DEPTH];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            cond;
  logic            br_valid;
  logic            misaligned;
  logic            accept;
  logic            trap_now;
  logic [IDXW-1:0] idx;
  logic [1:0]      ctr;
  logic [1:0]      ctr_next;
  logic            unused_instr;

  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign idx      = pc_q[IDXW+1:2];
  assign ctr      = bht[idx];
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = op1 + op3;
  assign accept   = enable & armed_q;

  always_comb begin
    target   = pc_q + op3;
    taken    = 1'b0;
    cond     = 1'b0;
    br_valid = 1'b0;
    case (instr[6:0])
      OPC_JAL: begin
        taken = 1'b1;
      end
      OPC_JALR: begin
        target = {jalr_sum[XLEN-1:1], 1'b0};
        taken  = 1'b1;
      end
      OPC_BRANCH: begin
        br_valid = 1'b1;
        case (instr[14:12])
          F3_BEQ:  cond = (op1 == op2);
          F3_BNE:  cond = (op1 != op2);
          F3_BLT:  cond = ($signed(op1) <  $signed(op2));
          F3_BGE:  cond = ($signed(op1) >= $signed(op2));
          F3_BLTU: cond = (op1 <  op2);
          F3_BGEU: cond = (op1 >= op2);
          default: br_valid = 1'b0;
        endcase
        taken = cond;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (ALIGN == 2) misaligned = target[0];
    else            misaligned = (target[1:0] != 2'b00);
  end

  assign trap_now = accept & taken & misaligned;
  assign next_pc  = taken ? target : pc_plus4;

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= XLEN'(RESET_PC);
      ret_q        <= '0;
      trap_addr_q  <= '0;
      mispredict_q <= 1'b0;
      trap_q       <= 1'b0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else begin
      armed_q      <= 1'b1;
      done_q       <= accept;
      trap_q       <= trap_now;
      mispredict_q <= 1'b0;
      if (trap_now) begin
        trap_addr_q <= target;
      end else if (accept) begin
        pc_q         <= next_pc;
        ret_q        <= pc_plus4;
        // Compare against the counter value before this update.
        mispredict_q <= br_valid & (taken != ctr[1]);
        if (br_valid) bht[idx] <= ctr_next;
      end
    end
  end

  assign pc_out        = pc_q;
  assign ret_addr      = ret_q;
  assign predict_taken = ctr[1];
  assign mispredict    = mispredict_q;
  assign trap          = trap_q;
  assign trap_addr     = trap_addr_q;
  assign done          = done_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
module tb_branch_unit_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] op1 = '0, op2 = '0, op3 = '0;

  logic [31:0] pc_a, ret_a, taddr_a, pc_b, ret_b, taddr_b;
  logic        pred_a, mis_a, trap_a, done_a, pred_b, mis_b, trap_b, done_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_unit_bht #(.XLEN(32), .RESET_PC(32'h100), .BHT_DEPTH(16), .ALIGN(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .instr(instr),
    .op1(op1), .op2(op2), .op3(op3),
    .pc_out(pc_a), .ret_addr(ret_a), .predict_taken(pred_a),
    .mispredict(mis_a), .trap(trap_a), .trap_addr(taddr_a), .done(done_a)
  );

  branch_unit_bht #(.XLEN(32), .RESET_PC(32'h100), .BHT_DEPTH(16), .ALIGN(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .instr(instr),
    .op1(op1), .op2(op2), .op3(op3),
    .pc_out(pc_b), .ret_addr(ret_b), .predict_taken(pred_b),
    .mispredict(mis_b), .trap(trap_b), .trap_addr(taddr_b), .done(done_b)
  );

  localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, BR = 7'h63, ALU = 7'h33, IMM = 7'h13;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'b0, f3, 5'b0, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model (both instances) ----------
  logic [31:0] m_pc [2];
  logic [31:0] m_ret [2];
  logic [31:0] m_taddr [2];
  int          m_cnt [2][16];
  logic        e_mis [2];
  logic        e_trap [2];
  logic        e_done [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h100; m_ret[k] = 0; m_taddr[k] = 0;
      e_mis[k] = 0; e_trap[k] = 0; e_done[k] = 0;
      for (int j = 0; j < 16; j++) m_cnt[k][j] = 1;
    end
  endtask

  task automatic model_step(input int k, input logic en, input logic [31:0] ins,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] tgt;
    bit tk, isbr, c;
    int al, ix;
    e_mis[k] = 0; e_trap[k] = 0; e_done[k] = en;
    if (!en) return;
    tk = 0; isbr = 0; c = 0;
    tgt = m_pc[k] + imm;
    case (ins[6:0])
      JAL:  tk = 1;
      JALR: begin tgt = (a + imm) & ~32'd1; tk = 1; end
      BR: begin
        isbr = 1;
        case (ins[14:12])
          3'd0: c = (a == b);
          3'd1: c = (a != b);
          3'd4: c = ($signed(a) < $signed(b));
          3'd5: c = ($signed(a) >= $signed(b));
          3'd6: c = (a < b);
          3'd7: c = (a >= b);
          default: isbr = 0;
        endcase
        tk = c;
      end
      default: ;
    endcase
    al = (k == 0) ? 4 : 2;
    if (tk && (tgt % al) != 0) begin
      e_trap[k] = 1;
      m_taddr[k] = tgt;
      return;
    end
    ix = (m_pc[k] / 4) % 16;
    if (isbr) begin
      e_mis[k] = (tk != (m_cnt[k][ix] >= 2));
      if (tk && m_cnt[k][ix] < 3) m_cnt[k][ix]++;
      if (!tk && m_cnt[k][ix] > 0) m_cnt[k][ix]--;
    end
    m_ret[k] = m_pc[k] + 4;
    m_pc[k]  = tk ? tgt : m_pc[k] + 4;
  endtask

  task automatic model_compare(input int k);
    logic [31:0] pc, ret, ta;
    logic pr, mi, tr, dn;
    if (k == 0) begin pc = pc_a; ret = ret_a; ta = taddr_a; pr = pred_a; mi = mis_a; tr = trap_a; dn = done_a; end
    else        begin pc = pc_b; ret = ret_b; ta = taddr_b; pr = pred_b; mi = mis_b; tr = trap_b; dn = done_b; end
    chk($sformatf("rnd%0d_pc", k), pc, m_pc[k]);
    chk($sformatf("rnd%0d_ret", k), ret, m_ret[k]);
    chk($sformatf("rnd%0d_taddr", k), ta, m_taddr[k]);
    chk($sformatf("rnd%0d_trap", k), 32'(tr), 32'(e_trap[k]));
    chk($sformatf("rnd%0d_mis", k), 32'(mi), 32'(e_mis[k]));
    chk($sformatf("rnd%0d_done", k), 32'(dn), 32'(e_done[k]));
    chk($sformatf("rnd%0d_pred", k), 32'(pr), 32'(m_cnt[k][(m_pc[k] / 4) % 16] >= 2));
  endtask

  task automatic do_reset();
    enable = 0;
    rst = 1;
    step();
    rst = 0;
    step();   // reset-release edge
    model_reset();
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic [31:0] ins, a, b, imm, pc, ret, taddr;
    logic        mis, trap, pred;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] ret,
                             input logic [31:0] taddr, input logic mis, input logic trap, input logic pred);
    vec_t r;
    r.ins = ins; r.a = a; r.b = b; r.imm = imm; r.pc = pc; r.ret = ret;
    r.taddr = taddr; r.mis = mis; r.trap = trap; r.pred = pred;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 10 sequential ALU ops from 0x100
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(mk(ALU, 3'd4), 0, 0, 0, 32'h104 + 4*i, 32'h104 + 4*i, 0, 0, 0, 0));
    tbl.push_back(v(mk(JAL, 0), 0, 0, 32'h20000, 32'h20128, 32'h12C, 0, 0, 0, 0));
    tbl.push_back(v(mk(JALR, 0), 32'h40001, 0, 0, 32'h40000, 32'h2012C, 0, 0, 0, 0));
    // same BEQ three times from 0x40000, returning via JALR
    tbl.push_back(v(mk(BR, 0), 1, 1, 32'h100, 32'h40100, 32'h40004, 0, 1, 0, 1));
    tbl.push_back(v(mk(JALR, 0), 32'h40000, 0, 0, 32'h40000, 32'h40104, 0, 0, 0, 1));
    tbl.push_back(v(mk(BR, 0), 1, 1, 32'h100, 32'h40100, 32'h40004, 0, 0, 0, 1));
    tbl.push_back(v(mk(JALR, 0), 32'h40000, 0, 0, 32'h40000, 32'h40104, 0, 0, 0, 1));
    tbl.push_back(v(mk(BR, 0), 1, 1, 32'h100, 32'h40100, 32'h40004, 0, 0, 0, 1));
    tbl.push_back(v(mk(JALR, 0), 32'h40000, 0, 0, 32'h40000, 32'h40104, 0, 0, 0, 1));
    tbl.push_back(v(mk(BR, 1), 1, 1, 32'h100, 32'h40004, 32'h40004, 0, 1, 0, 0));
    // BLT taken to a 2-byte-aligned target: trap with ALIGN=4
    tbl.push_back(v(mk(BR, 4), 32'hFFFF_FFFF, 1, 32'h102, 32'h40004, 32'h40004, 32'h40106, 0, 1, 0));

    // Reset state
    rst = 1;
    step();
    chk("rst_async_pc", pc_a, 32'h100);
    rst = 0;
    step();
    chk("rst_pc", pc_a, 32'h100);
    chk("rst_ret", ret_a, 0);
    chk("rst_taddr", taddr_a, 0);
    chk("rst_pred", 32'(pred_a), 0);
    chk("rst_pulses", {29'b0, mis_a, trap_a, done_a}, 0);

    foreach (tbl[i]) begin
      instr = tbl[i].ins; op1 = tbl[i].a; op2 = tbl[i].b; op3 = tbl[i].imm;
      enable = 1;
      step();
      chk($sformatf("vec%0d_pc", i), pc_a, tbl[i].pc);
      chk($sformatf("vec%0d_ret", i), ret_a, tbl[i].ret);
      chk($sformatf("vec%0d_taddr", i), taddr_a, tbl[i].taddr);
      chk($sformatf("vec%0d_mis", i), 32'(mis_a), 32'(tbl[i].mis));
      chk($sformatf("vec%0d_trap", i), 32'(trap_a), 32'(tbl[i].trap));
      chk($sformatf("vec%0d_pred", i), 32'(pred_a), 32'(tbl[i].pred));
      chk($sformatf("vec%0d_done", i), 32'(done_a), 1);
    end
    enable = 0;
    step();
    chk("idle_done", 32'(done_a), 0);
    chk("idle_trap", 32'(trap_a), 0);
    chk("idle_taddr_held", taddr_a, 32'h40106);
    chk("idle_pc_held", pc_a, 32'h40004);

    // ALIGN=2 vs ALIGN=4 on the same misaligned-for-4 branch
    do_reset();
    instr = mk(BR, 4); op1 = 32'hFFFF_FFFF; op2 = 1; op3 = 32'h102; enable = 1;
    step();
    enable = 0;
    chk("al4_trap", 32'(trap_a), 1);
    chk("al4_pc", pc_a, 32'h100);
    chk("al4_taddr", taddr_a, 32'h202);
    chk("al4_mis", 32'(mis_a), 0);
    chk("al2_trap", 32'(trap_b), 0);
    chk("al2_pc", pc_b, 32'h202);
    chk("al2_mis", 32'(mis_b), 1);

    // PC wrap, then reset asserted while enable is held
    instr = mk(JALR, 0); op1 = 32'hFFFF_FFFC; op3 = 0; enable = 1;
    step();
    chk("wrap_pre_pc", pc_a, 32'hFFFF_FFFC);
    instr = mk(IMM, 0);
    step();
    chk("wrap_pc", pc_a, 0);
    chk("wrap_ret", ret_a, 0);
    chk("wrap_trap", 32'(trap_a), 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_pc", pc_a, 32'h100);
    chk("midrst_done", 32'(done_a), 0);
    step();
    rst = 0;
    step();
    chk("release_ignored_pc", pc_a, 32'h100);
    chk("release_ignored_done", 32'(done_a), 0);
    step();
    chk("post_release_pc", pc_a, 32'h104);
    chk("post_release_done", 32'(done_a), 1);
    enable = 0;

    // Randomised run against the reference model
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic en;
      logic [6:0] opc;
      int sel;
      en = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      opc = (sel < 2) ? JAL : (sel < 4) ? JALR : (sel < 8) ? BR : ALU;
      instr = mk(opc, 3'($urandom_range(0, 7)));
      op1 = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      op2 = 32'($urandom_range(0, 4)) - 32'd2;
      op3 = 32'($signed($urandom_range(0, 64)) - 32) * (($urandom_range(0, 3) == 0) ? 2 : 4);
      if (opc == JALR) op1 = m_pc[0] + 32'($urandom_range(0, 7));
      enable = en;
      model_step(0, en, instr, op1, op2, op3);
      model_step(1, en, instr, op1, op2, op3);
      step();
      model_compare(0);
      model_compare(1);
    end
    enable = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
